boot_run_ctrl: RTL and testbench

Sequencer that owns bring-up of the single-cycle core. It holds the core in reset while it loads a program image into instruction memory from a byte-serial stream, then releases the core and counts run cycles. It also supports halt and resume. It sits between the top-level clock/reset and the instruction-memory write port of `SINGLE_CYCLE_TOP`, and drives the core's active-low reset.

---
 rtl/boot_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_boot_run_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: bring-up sequencer for the single-cycle core.
// Loads a program image from a byte stream into IMEM while holding the
// core in reset, then releases the core and counts run cycles. Supports
// halt/resume and aborting a load.
module boot_run_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic [31:0]           run_cycles,
    output logic [1:0]            state,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // Largest image: 2^ADDR_WIDTH words.
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              st_q;
    state_t              st_d;
    logic [ADDR_WIDTH:0] len_q;       // captured (clamped) image length
    logic [ADDR_WIDTH:0] widx_q;      // index of the next word to write
    logic [ADDR_WIDTH:0] widx_inc;
    logic [1:0]          bcnt_q;      // bytes already held for the current word
    logic [23:0]         buf_q;       // first three bytes, little-endian
    logic                last_q;      // the word being written is the final one
    logic [31:0]         run_q;
    logic                err_q;

    logic                start_ok;
    logic                final_wr;
    logic                byte_ok;
    logic [ADDR_WIDTH:0] len_clamped;

    // Byte stream handshake: a byte moves on every rising edge where
    // rx_valid && rx_ready. rx_ready is a pure function of registered state
    // (never of rx_valid), is high throughout LOAD, and drops only during
    // the cycle in which the final word is being written. A byte offered
    // in the same cycle as halt_req during LOAD is dropped with the abort.
    assign final_wr  = imem_we && last_q;
    assign rx_ready  = (st_q == S_LOAD) && !final_wr;
    assign byte_ok   = rx_valid && rx_ready && !halt_req;

    // load_start is honoured in IDLE, and in HALT unless halt_req is also
    // asserted (halt_req keeps the block parked in HALT).
    assign start_ok    = load_start &&
                         ((st_q == S_IDLE) || ((st_q == S_HALT) && !halt_req));
    assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign widx_inc    = widx_q + IDX_ONE;

    assign core_rst   = (st_q == S_RUN);
    assign run_cycles = run_q;
    assign state      = st_q;
    assign err        = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Next-state logic.
    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE: begin
                if (start_ok) begin
                    st_d = (len_clamped == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (halt_req) begin
                    st_d = S_IDLE;
                end else if (final_wr) begin
                    st_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    st_d = S_HALT;
                end
            end
            S_HALT: begin
                if (halt_req) begin
                    st_d = S_HALT;
                end else if (start_ok) begin
                    st_d = (len_clamped == '0) ? S_RUN : S_LOAD;
                end else if (resume) begin
                    st_d = S_RUN;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Word assembly, IMEM write strobe and abort bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            widx_q     <= '0;
            bcnt_q     <= 2'd0;
            buf_q      <= 24'd0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                len_q  <= len_clamped;
                widx_q <= '0;
                bcnt_q <= 2'd0;
                buf_q  <= 24'd0;
                last_q <= 1'b0;
                err_q  <= 1'b0;
            end else if ((st_q == S_LOAD) && halt_req) begin
                // Abort: drop the partial word, remember that it happened.
                err_q  <= 1'b1;
                bcnt_q <= 2'd0;
                buf_q  <= 24'd0;
            end else if (byte_ok) begin
                if (bcnt_q == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= widx_q[ADDR_WIDTH-1:0];
                    imem_wdata <= {rx_data, buf_q};
                    widx_q     <= widx_inc;
                    last_q     <= (widx_inc == len_q);
                    bcnt_q     <= 2'd0;
                end else begin
                    buf_q  <= {rx_data, buf_q[23:8]};
                    bcnt_q <= bcnt_q + 2'd1;
                end
            end
        end
    end

    // Run-cycle counter: cleared on a new load/run request, counts every
    // cycle the core is out of reset, frozen otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 32'd0;
        end else if (start_ok) begin
            run_q <= 32'd0;
        end else if (st_q == S_RUN) begin
            run_q <= run_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Testbench for boot_run_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural
// model of the sequencer.
module tb_boot_run_ctrl;

    localparam int AW   = 4;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          halt_req = 1'b0;
    logic          resume = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic [31:0]   run_cycles;
    logic [1:0]    state;
    logic          err;

    boot_run_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .halt_req   (halt_req),
        .resume     (resume),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .run_cycles (run_cycles),
        .state      (state),
        .err        (err)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: writes seen on the IMEM port vs. writes a scenario expects.
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];

    // Behavioural model: mode 0..3 = idle/load/run/halt.
    int          m_state;
    bit          m_we;
    bit          m_last;
    int          m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_run;
    bit          m_err;
    int          m_len;
    int          m_widx;
    byte unsigned part[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_rx_ready();
        return (m_state == 1) && !(m_we && m_last);
    endfunction

    task automatic model_reset();
        m_state = 0; m_we = 0; m_last = 0; m_addr = 0; m_wdata = 32'd0;
        m_run = 32'd0; m_err = 0; m_len = 0; m_widx = 0;
        part.delete();
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int nxt;
        bit start;
        bit xfer;
        bit fin;
        if (!rst) begin
            model_reset();
            return;
        end
        nxt   = m_state;
        start = load_start && (m_state == 0 || (m_state == 3 && !halt_req));
        xfer  = rx_valid && exp_rx_ready();
        fin   = m_we && m_last;
        m_we  = 0;
        if (m_state == 2) m_run = m_run + 32'd1;
        if (start) begin
            m_len  = (int'(load_len) > MAXW) ? MAXW : int'(load_len);
            m_widx = 0;
            m_run  = 32'd0;
            m_err  = 0;
            part.delete();
            nxt = (m_len == 0) ? 2 : 1;
        end else begin
            case (m_state)
                1: begin
                    if (halt_req) begin
                        m_err = 1;
                        part.delete();
                        nxt = 0;
                    end else begin
                        if (xfer) begin
                            part.push_back(rx_data);
                            if (part.size() == 4) begin
                                m_we    = 1;
                                m_addr  = m_widx % MAXW;
                                m_wdata = 32'd0;
                                for (int i = 0; i < 4; i++)
                                    m_wdata = m_wdata | (32'(part[i]) << (8 * i));
                                m_widx++;
                                m_last = (m_widx == m_len);
                                part.delete();
                            end
                        end
                        if (fin) nxt = 2;
                    end
                end
                2: if (halt_req) nxt = 3;
                3: if (!halt_req && resume) nxt = 2;
                default: ;
            endcase
        end
        m_state = nxt;
    endtask

    task automatic compare_all();
        chk("state",      32'(state),      32'(m_state));
        chk("core_rst",   32'(core_rst),   32'(m_state == 2));
        chk("rx_ready",   32'(rx_ready),   32'(exp_rx_ready()));
        chk("imem_we",    32'(imem_we),    32'(m_we));
        chk("imem_addr",  32'(imem_addr),  32'(m_addr));
        chk("imem_wdata", imem_wdata,      m_wdata);
        chk("run_cycles", run_cycles,      m_run);
        chk("err",        32'(err),        32'(m_err));
        if (imem_we === 1'b1) wr_q.push_back({32'(imem_addr), imem_wdata});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr_addr"}, wr_q[i][63:32], exp_q[i][63:32]);
            chk({tag, "_wr_data"}, wr_q[i][31:0],  exp_q[i][31:0]);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"},      32'(state),      32'd0);
        chk({tag, "_core_rst"},   32'(core_rst),   32'd0);
        chk({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
        chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
        chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_run_cycles"}, run_cycles,      32'd0);
        chk({tag, "_err"},        32'(err),        32'd0);
    endtask

    logic [7:0] img [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        logic [7:0]  rb;
        logic [31:0] w;

        // Reset block
        model_reset();
        #2;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Two-word load, back-to-back bytes
        pulse_start(2);
        chk("load_state", 32'(state), 32'd1);
        chk("load_rx_ready", 32'(rx_ready), 32'd1);
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd1, 32'h0010_0093});
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        chk("final_we", 32'(imem_we), 32'd1);
        chk("final_core_held", 32'(core_rst), 32'd0);
        chk("final_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        chk("release_core_rst", 32'(core_rst), 32'd1);
        chk("release_state", 32'(state), 32'd2);
        chk("release_run0", run_cycles, 32'd0);
        tick();
        chk("release_run1", run_cycles, 32'd1);
        check_writes("two_word");
        pulse_halt();
        chk("halt_state", 32'(state), 32'd3);

        // Same image, 3 idle cycles between bytes
        pulse_start(2);
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd1, 32'h0010_0093});
        for (int i = 0; i < 8; i++) begin
            send_byte(img[i]);
            for (int g = 0; g < 3; g++) tick();
        end
        chk("gapped_state", 32'(state), 32'd2);
        check_writes("gapped");
        pulse_halt();

        // Zero length, then halt/resume
        pulse_start(0);
        chk("zero_state", 32'(state), 32'd2);
        chk("zero_core_rst", 32'(core_rst), 32'd1);
        chk("zero_run0", run_cycles, 32'd0);
        tick(); chk("zero_run1", run_cycles, 32'd1);
        tick(); chk("zero_run2", run_cycles, 32'd2);
        tick(); chk("zero_run3", run_cycles, 32'd3);
        for (int i = 0; i < 6; i++) tick();
        pulse_halt();
        chk("hr_halt_state", 32'(state), 32'd3);
        chk("hr_frozen", run_cycles, 32'd10);
        for (int i = 0; i < 5; i++) tick();
        chk("hr_frozen5", run_cycles, 32'd10);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("hr_resume_state", 32'(state), 32'd2);
        tick();
        chk("hr_continue", run_cycles, 32'd11);
        pulse_halt();
        halt_req = 1'b1;
        resume   = 1'b1;
        tick();
        halt_req = 1'b0;
        resume   = 1'b0;
        chk("hr_both_state", 32'(state), 32'd3);
        check_writes("zero_len");

        // Abort after 6 bytes of a 4-word load
        pulse_start(4);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        pulse_halt();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_core_rst", 32'(core_rst), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        exp_q.push_back({32'd0, 32'h1312_1110});
        check_writes("abort");
        pulse_start(1);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_state", 32'(state), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'ha0 + i));
        tick();
        exp_q.push_back({32'd0, 32'ha3a2_a1a0});
        check_writes("restart");
        chk("restart_run_state", 32'(state), 32'd2);

        // Oversized length is clamped to the IMEM depth
        pulse_halt();
        pulse_start(20);
        for (int wi = 0; wi < MAXW; wi++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                rb = 8'($urandom_range(0, 255));
                w  = w | (32'(rb) << (8 * b));
                send_byte(rb);
            end
            exp_q.push_back({32'(wi), w});
        end
        tick();
        chk("clamp_state", 32'(state), 32'd2);
        check_writes("clamp");

        // Asynchronous reset in the middle of a load
        pulse_halt();
        pulse_start(3);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
        wr_q.delete();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_no_write", 32'(wr_q.size()), 32'd0);
        wr_q.delete();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            load_start = ($urandom_range(0, 9) == 0);
            load_len   = ($urandom_range(0, 3) == 0) ? (AW+1)'($urandom_range(0, 31))
                                                     : (AW+1)'($urandom_range(0, 4));
            rx_valid   = ($urandom_range(0, 9) < 7);
            rx_data    = 8'($urandom_range(0, 255));
            halt_req   = ($urandom_range(0, 149) == 0);
            resume     = ($urandom_range(0, 7) == 0);
            rst        = !($urandom_range(0, 999) == 0);
            tick();
        end
        load_start = 1'b0;
        rx_valid   = 1'b0;
        halt_req   = 1'b0;
        resume     = 1'b0;
        rst        = 1'b1;
        tick();

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
